// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: seven two-operand gate ops selected per transaction,
// one output slot with valid/ready on both sides, reduction flags and a saturating done count.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor,
    output logic             op_err,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [WIDTH-1:0] res_d;
    logic             err_d;
    logic             in_acc;
    logic             out_acc;

    logic             vld_p0;
    logic [WIDTH-1:0] res_p0;
    logic             rand_p0;
    logic             ror_p0;
    logic             rxor_p0;
    logic             err_p0;
    logic [CNT_W-1:0] cnt_p0;

    assign in_ready = !vld_p0 || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = vld_p0 && out_ready;

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (op)
            3'd0:    res_d = a & b;
            3'd1:    res_d = a | b;
            3'd2:    res_d = ~a;
            3'd3:    res_d = ~(a & b);
            3'd4:    res_d = ~(a | b);
            3'd5:    res_d = a ^ b;
            3'd6:    res_d = ~(a ^ b);
            default: err_d = 1'b1;
        endcase
    end

    // Output stage: loads on input accept, drains on output accept, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            res_p0  <= '0;
            rand_p0 <= 1'b0;
            ror_p0  <= 1'b0;
            rxor_p0 <= 1'b0;
            err_p0  <= 1'b0;
            cnt_p0  <= '0;
        end else begin
            if (in_acc) begin
                vld_p0  <= 1'b1;
                res_p0  <= res_d;
                rand_p0 <= &res_d;
                ror_p0  <= |res_d;
                rxor_p0 <= ^res_d;
                err_p0  <= err_d;
            end else if (out_acc) begin
                vld_p0  <= 1'b0;
            end
            if (out_acc) begin
                cnt_p0 <= sat_inc(cnt_p0);
            end
        end
    end

    assign out_valid = vld_p0;
    assign result    = res_p0;
    assign red_and   = rand_p0;
    assign red_or    = ror_p0;
    assign red_xor   = rxor_p0;
    assign op_err    = err_p0;
    assign done_cnt  = cnt_p0;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a WIDTH=8/CNT_W=16 instance and a CNT_W=2 instance
// share the same stimulus; every expected value is a hand-computed constant.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;

    logic        in_ready, out_valid, red_and, red_or, red_xor, op_err;
    logic [7:0]  result;
    logic [15:0] done_cnt;

    logic        in_ready2, out_valid2, red_and2, red_or2, red_xor2, op_err2;
    logic [7:0]  result2;
    logic [1:0]  done_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .red_and(red_and), .red_or(red_or), .red_xor(red_xor),
        .op_err(op_err), .done_cnt(done_cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2), .red_and(red_and2), .red_or(red_or2), .red_xor(red_xor2),
        .op_err(op_err2), .done_cnt(done_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_res [7];
    logic [1:0] exp_sat [7];

    initial begin
        exp_res = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55};
        exp_sat = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        rst_n = 1'b1;

        // Idle with random operands: nothing may change
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
            out_ready = 1'($urandom);
            tick();
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready",  32'(in_ready),  32'd1);
            chk("idle_result",    32'(result),    32'd0);
            chk("idle_flags",     32'({red_and, red_or, red_xor, op_err}), 32'd0);
            chk("idle_done",      32'(done_cnt),  32'd0);
        end

        // Back-to-back ops 0..6 on A5/0F
        out_ready = 1'b1; in_valid = 1'b1; a = 8'hA5; b = 8'h0F;
        for (int i = 0; i < 7; i++) begin
            op = 3'(i);
            tick();
            chk("ops_result",   32'(result),    32'(exp_res[i]));
            chk("ops_valid",    32'(out_valid), 32'd1);
            chk("ops_flags",    32'({red_and, red_or, red_xor, op_err}), 32'b0100);
            chk("ops_done",     32'(done_cnt),  32'(i));
            chk("sat_result",   32'(result2),   32'(exp_res[i]));
            chk("sat_done",     32'(done_cnt2), 32'(exp_sat[i]));
            chk("sat_ctl",      32'({in_ready2, out_valid2, red_and2, red_or2, red_xor2, op_err2}), 32'b110100);
        end
        in_valid = 1'b0;
        tick();
        chk("ops_drain_valid", 32'(out_valid), 32'd0);
        chk("ops_done_final",  32'(done_cnt),  32'd7);
        chk("sat_done_final",  32'(done_cnt2), 32'd3);

        // Back-pressure
        in_valid = 1'b1; a = 8'hFF; b = 8'h3C; op = 3'd0;
        tick();
        chk("bp_load", 32'(result), 32'h3C);
        out_ready = 1'b0; a = 8'h12; b = 8'h34; op = 3'd1;
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_result", 32'(result),    32'h3C);
            chk("bp_hold_valid",  32'(out_valid), 32'd1);
            chk("bp_in_ready",    32'(in_ready),  32'd0);
            chk("bp_done",        32'(done_cnt),  32'd7);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_next_result", 32'(result),    32'h36);
        chk("bp_next_valid",  32'(out_valid), 32'd1);
        chk("bp_done_inc",    32'(done_cnt),  32'd8);

        // Illegal opcode then recovery
        a = 8'hFF; b = 8'hFF; op = 3'd7;
        tick();
        chk("err_result", 32'(result), 32'h00);
        chk("err_flags",  32'({red_and, red_or, red_xor, op_err}), 32'b0001);
        chk("err_done",   32'(done_cnt), 32'd9);
        op = 3'd0;
        tick();
        chk("clr_result", 32'(result), 32'hFF);
        chk("clr_flags",  32'({red_and, red_or, red_xor, op_err}), 32'b1100);
        chk("clr_done",   32'(done_cnt), 32'd10);
        in_valid = 1'b0;
        tick();
        chk("err_drain_done",  32'(done_cnt),  32'd11);
        chk("err_drain_valid", 32'(out_valid), 32'd0);

        // Reset while a result is stalled
        in_valid = 1'b1; a = 8'hC3; b = 8'h00; op = 3'd1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("mid_pending", 32'(result), 32'hC3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(out_valid), 32'd0);
        chk("mid_rst_result", 32'(result),    32'd0);
        chk("mid_rst_done",   32'(done_cnt),  32'd0);
        chk("mid_rst_err",    32'(op_err),    32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_done",  32'(done_cnt),  32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the basic two-input gate set: applies one of seven bitwise logic operations to WIDTH-bit operands, chosen per transaction by an opcode.
- Single output-register stage with valid/ready handshakes on both sides, so it can sit in a streaming datapath and absorb downstream back-pressure.
- Also registers reduction flags of the result, flags illegal opcodes, and keeps a saturating count of completed transactions.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 16, width of the completed-transaction counter (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  block can accept a transaction this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for NOT)
- op  input  3  opcode: 0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered bitwise result
- red_and  output  1  AND-reduction of result
- red_or  output  1  OR-reduction of result
- red_xor  output  1  XOR-reduction (parity) of result
- op_err  output  1  registered result came from opcode 7
- done_cnt  output  CNT_W  saturating count of output handshakes

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-edge release):
  - out_valid=0, result=0, red_and=0, red_or=0, red_xor=0, op_err=0, done_cnt=0.
  - in_ready reads 1 once reset is released.
- Handshake:
  - Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational; one slot with pass-through). Full throughput of one transaction per cycle when out_ready stays high.
- Latency: the result registered on accept edge N is visible with out_valid=1 in the cycle after edge N.
- Register update on each clk edge:
  - Input accept: load result, reduction flags and op_err from the current a/b/op; out_valid <= 1. This applies regardless of a simultaneous output accept (back-to-back streaming).
  - Output accept without input accept: out_valid <= 0. result and flags hold their last values.
  - Neither: all registers hold. While out_valid=1 and out_ready=0, result, flags and op_err must stay stable.
- Operations: bitwise across all WIDTH bits.
  - NOT uses a only.
  - Opcode 7: result=0, red_and=0, red_or=0, red_xor=0, op_err=1. The transaction is still accepted, emitted and counted.
- Reductions are computed from the value being loaded into result, so they are coherent with result in the same cycle.
- done_cnt:
  - Increments by 1 on each output accept.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- in_valid low: no state change, whatever the a/b/op values. Inputs are not sampled unless accepted.
- Reset mid-stream: a pending result is discarded, out_valid drops immediately (asynchronously), and no handshake completes in that cycle.
- WIDTH=1: reductions equal result.

Test Plan:
- Reset then idle, WIDTH=8 -> all outputs 0, in_ready=1, done_cnt=0 over 10 idle cycles with random a/b/op and in_valid=0.
- a=8'hA5, b=8'h0F, out_ready=1, ops 0..6 back-to-back -> results 05, AF, 5A, FA, 50, AA, 55 on consecutive cycles, each one cycle after its accept. red_xor for the sequence is 0,0,0,0,0,0,0; done_cnt=7.
- Back-pressure: accept AND of FF,3C, then hold out_ready=0 for 5 cycles while in_valid=1 with new data -> result stays 3C, in_ready=0, no new data taken. Raising out_ready gives 3C accepted and the next input loaded on the same edge.
- op=7, a=FF, b=FF -> result=00, op_err=1, red_or=0, done_cnt increments. A following op=0 clears op_err to 0.
- CNT_W=2 bench: 6 output handshakes -> done_cnt reads 1,2,3,3,3,3.
- Assert rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 and result=0 before the next clk edge. After release, in_ready=1 and the stale result is never emitted.
